// File: rtl/ans_rans_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ans_rans_encoder
// Function : rANS entropy encoder with a loadable frequency table, serial
//            cumulative-frequency scan and a bit-serial restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module ans_rans_encoder #(
    parameter int SYM_WIDTH   = 4,
    parameter int PROB_BITS   = 8,
    parameter int STATE_WIDTH = 16,
    parameter int OUT_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             cmd,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [SYM_WIDTH-1:0]   in_sym,
    input  logic [PROB_BITS-1:0]   in_freq,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   out_last,
    output logic                   table_ok,
    output logic                   err
);

    localparam int c_SYM_COUNT = 2**SYM_WIDTH;
    localparam int c_TOT_W     = PROB_BITS + SYM_WIDTH;
    localparam int c_NCHUNK    = STATE_WIDTH / OUT_WIDTH;
    localparam int c_CNT_W     = $clog2(STATE_WIDTH);

    localparam logic [STATE_WIDTH-1:0] c_L    = STATE_WIDTH'(1) << (STATE_WIDTH - OUT_WIDTH);
    localparam logic [c_TOT_W-1:0]     c_FULL = c_TOT_W'(1) << PROB_BITS;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD   = 3'd1;
    localparam logic [2:0] c_ST_CUM    = 3'd2;
    localparam logic [2:0] c_ST_RENORM = 3'd3;
    localparam logic [2:0] c_ST_DIV    = 3'd4;
    localparam logic [2:0] c_ST_UPDATE = 3'd5;
    localparam logic [2:0] c_ST_FLUSH  = 3'd6;

    logic [2:0]             r_state, w_next;
    logic [STATE_WIDTH-1:0] r_x;
    logic [PROB_BITS-1:0]   r_freq [c_SYM_COUNT];
    logic [c_TOT_W-1:0]     r_total;
    logic                   r_table_ok;
    logic                   r_err;
    logic [SYM_WIDTH-1:0]   r_sym;
    logic [SYM_WIDTH-1:0]   r_idx;
    logic [PROB_BITS-1:0]   r_fin;
    logic [PROB_BITS-1:0]   r_f;
    logic [PROB_BITS-1:0]   r_c;
    logic [STATE_WIDTH-1:0] r_q;
    logic [PROB_BITS-1:0]   r_rem;
    logic [c_CNT_W-1:0]     r_cnt;

    logic [STATE_WIDTH-1:0] w_x_max;
    logic                   w_renorm_emit;
    logic [PROB_BITS:0]     w_trial;
    logic                   w_trial_ge;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic                   w_enc_bad;
    logic                   w_last_chunk;
    logic [STATE_WIDTH-1:0] w_update;

    assign table_ok      = r_table_ok;
    assign err           = r_err;
    assign w_x_max       = {r_f, {(STATE_WIDTH-PROB_BITS){1'b0}}};
    assign w_renorm_emit = (r_x >= w_x_max);
    // Divider shifts the dividend MSB-first out of r_q into the remainder.
    assign w_trial       = {r_rem, r_q[STATE_WIDTH-1]};
    assign w_trial_ge    = (w_trial >= {1'b0, r_f});
    assign w_in_hs       = in_vld && in_rdy;
    assign w_out_hs      = out_vld && out_rdy;
    assign w_enc_bad     = (r_freq[in_sym] == '0) || !r_table_ok;
    assign w_last_chunk  = (r_cnt == c_CNT_W'(c_NCHUNK - 1));
    assign w_update      = (r_q << PROB_BITS) + STATE_WIDTH'(r_rem) + STATE_WIDTH'(r_c);

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        in_rdy   = 1'b0;
        out_vld  = 1'b0;
        out_last = 1'b0;
        out_data = '0;
        case (r_state)
            c_ST_IDLE: begin
                in_rdy = (cmd != 2'b00) && !rst;
                if (w_in_hs) begin
                    case (cmd)
                        2'b11:   w_next = c_ST_LOAD;
                        2'b10:   w_next = c_ST_FLUSH;
                        2'b01:   if (!w_enc_bad) w_next = (in_sym == '0) ? c_ST_RENORM : c_ST_CUM;
                        default: w_next = c_ST_IDLE;
                    endcase
                end
            end
            c_ST_LOAD:   w_next = c_ST_IDLE;
            c_ST_CUM:    if ((r_idx + 1'b1) == r_sym) w_next = c_ST_RENORM;
            c_ST_RENORM: begin
                if (w_renorm_emit) begin
                    out_vld  = 1'b1;
                    out_data = r_x[OUT_WIDTH-1:0];
                end else begin
                    w_next = c_ST_DIV;
                end
            end
            c_ST_DIV:    if (r_cnt == '0) w_next = c_ST_UPDATE;
            c_ST_UPDATE: w_next = c_ST_IDLE;
            c_ST_FLUSH: begin
                out_vld  = 1'b1;
                out_data = r_x[OUT_WIDTH-1:0];
                out_last = w_last_chunk;
                if (w_out_hs && w_last_chunk) w_next = c_ST_IDLE;
            end
            default:     w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= c_L;
            for (int i = 0; i < c_SYM_COUNT; i++) r_freq[i] <= '0;
            r_total    <= '0;
            r_table_ok <= 1'b0;
            r_err      <= 1'b0;
            r_sym      <= '0;
            r_idx      <= '0;
            r_fin      <= '0;
            r_f        <= '0;
            r_c        <= '0;
            r_q        <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
        end else begin
            r_table_ok <= (r_total == c_FULL);
            case (r_state)
                c_ST_IDLE: begin
                    if (w_in_hs) begin
                        r_sym <= in_sym;
                        r_fin <= in_freq;
                        r_f   <= r_freq[in_sym];
                        r_c   <= '0;
                        r_idx <= '0;
                        r_cnt <= '0;
                        if (cmd == 2'b01 && w_enc_bad) r_err <= 1'b1;
                    end
                end
                c_ST_LOAD: begin
                    r_total        <= r_total + c_TOT_W'(r_fin) - c_TOT_W'(r_freq[r_sym]);
                    r_freq[r_sym]  <= r_fin;
                end
                c_ST_CUM: begin
                    r_c   <= r_c + r_freq[r_idx];
                    r_idx <= r_idx + 1'b1;
                end
                c_ST_RENORM: begin
                    if (w_renorm_emit) begin
                        if (w_out_hs) r_x <= r_x >> OUT_WIDTH;
                    end else begin
                        r_q   <= r_x;
                        r_rem <= '0;
                        r_cnt <= c_CNT_W'(STATE_WIDTH - 1);
                    end
                end
                c_ST_DIV: begin
                    if (w_trial_ge) r_rem <= PROB_BITS'(w_trial - {1'b0, r_f});
                    else            r_rem <= w_trial[PROB_BITS-1:0];
                    r_q   <= {r_q[STATE_WIDTH-2:0], w_trial_ge};
                    r_cnt <= r_cnt - 1'b1;
                end
                c_ST_UPDATE: r_x <= w_update;
                c_ST_FLUSH: begin
                    if (w_out_hs) begin
                        if (w_last_chunk) begin
                            r_x <= c_L;
                        end else begin
                            r_x   <= r_x >> OUT_WIDTH;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ans_rans_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ans_rans_encoder
// Function : Directed self-checking bench for ans_rans_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ans_rans_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cmd = 2'b00;
    logic       in_vld = 1'b0;
    logic       in_rdy;
    logic [3:0] in_sym = '0;
    logic [7:0] in_freq = '0;
    logic [3:0] out_data;
    logic       out_vld;
    logic       out_rdy = 1'b1;
    logic       out_last;
    logic       table_ok;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] q_data [$];
    logic       q_last [$];

    always #5 clk = ~clk;

    ans_rans_encoder #(
        .SYM_WIDTH(4), .PROB_BITS(8), .STATE_WIDTH(16), .OUT_WIDTH(4)
    ) u_dut (
        .clk(clk), .rst(rst), .cmd(cmd), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_sym(in_sym), .in_freq(in_freq), .out_data(out_data), .out_vld(out_vld),
        .out_rdy(out_rdy), .out_last(out_last), .table_ok(table_ok), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one command and returns just after the accepting edge.
    task automatic send(input logic [1:0] c, input logic [3:0] s, input logic [7:0] f);
        bit done = 0;
        @(negedge clk);
        cmd = c; in_sym = s; in_freq = f; in_vld = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_rdy) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        in_vld = 1'b0;
        cmd = 2'b01;
        if (!done) chk("send_timeout", 32'd1, 32'd0);
    endtask

    // Collects chunks until the FSM is back in IDLE; bp>0 stalls the first chunk.
    task automatic wait_idle(input int bp, output int cyc);
        int hold = bp;
        bit first = 1;
        bit done = 0;
        logic [3:0] d0 = '0;
        logic       l0 = 1'b0;
        cyc = 0;
        q_data.delete();
        q_last.delete();
        out_rdy = (bp == 0);
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_rdy) begin
                done = 1;
            end else begin
                if (out_vld && !out_rdy) begin
                    if (first) begin
                        d0 = out_data; l0 = out_last; first = 0;
                    end else begin
                        chk("bp_data_stable", 32'(out_data), 32'(d0));
                        chk("bp_last_stable", 32'(out_last), 32'(l0));
                    end
                    hold--;
                    if (hold <= 0) out_rdy = 1'b1;
                end
                if (out_vld && out_rdy) begin
                    q_data.push_back(out_data);
                    q_last.push_back(out_last);
                end
                cyc++;
            end
        end
        out_rdy = 1'b1;
        if (!done) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic expect_seq(input string tag, input int n, input logic [15:0] exp, input bit flush);
        logic [15:0] e = exp;
        chk({tag, "_count"}, 32'(q_data.size()), 32'(n));
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            chk({tag, "_data"}, 32'(q_data[i]), 32'(e[4*i +: 4]));
            chk({tag, "_last"}, 32'(q_last[i]), 32'(flush && (i == n - 1)));
        end
    endtask

    task automatic load(input logic [3:0] s, input logic [7:0] f);
        int cyc;
        send(2'b11, s, f);
        wait_idle(0, cyc);
    endtask

    task automatic load_uniform();
        for (int i = 0; i < 16; i++) load(4'(i), 8'd16);
        @(negedge clk);
    endtask

    initial begin
        int cyc;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_table_ok", 32'(table_ok), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_in_rdy_idle_cmd", 32'(in_rdy), 0);

        // Encode against an empty table
        send(2'b01, 4'd3, 8'd0);
        wait_idle(0, cyc);
        chk("emptytab_err", 32'(err), 1);
        chk("emptytab_chunks", 32'(q_data.size()), 0);
        send(2'b10, 4'd0, 8'd0);
        wait_idle(0, cyc);
        expect_seq("emptytab_flush", 4, 16'h1000, 1);
        chk("emptytab_err_held", 32'(err), 1);

        // Uniform table
        do_reset();
        load_uniform();
        chk("uni_table_ok", 32'(table_ok), 1);
        send(2'b01, 4'd0, 8'd0);
        wait_idle(0, cyc);
        expect_seq("uni_enc0", 1, 16'h0000, 0);
        chk("uni_enc0_latency", 32'(cyc), 32'd19);
        send(2'b01, 4'd5, 8'd0);
        wait_idle(0, cyc);
        expect_seq("uni_enc5", 1, 16'h0000, 0);
        chk("uni_enc5_latency", 32'(cyc), 32'd24);
        send(2'b10, 4'd0, 8'd0);
        wait_idle(10, cyc);
        expect_seq("uni_flush_bp", 4, 16'h1050, 1);
        send(2'b10, 4'd0, 8'd0);
        wait_idle(0, cyc);
        expect_seq("uni_flush_again", 4, 16'h1000, 1);
        chk("uni_err", 32'(err), 0);

        // Reload one entry so the table no longer sums to 256
        load(4'd2, 8'd32);
        @(negedge clk);
        chk("reload_table_bad", 32'(table_ok), 0);
        send(2'b01, 4'd1, 8'd0);
        wait_idle(0, cyc);
        chk("reload_err", 32'(err), 1);
        chk("reload_chunks", 32'(q_data.size()), 0);
        load(4'd2, 8'd16);
        @(negedge clk);
        chk("restore_table_ok", 32'(table_ok), 1);
        chk("restore_err_sticky", 32'(err), 1);

        // Skewed table
        do_reset();
        load(4'd0, 8'd241);
        for (int i = 1; i < 16; i++) load(4'(i), 8'd1);
        @(negedge clk);
        chk("skew_table_ok", 32'(table_ok), 1);
        send(2'b01, 4'd1, 8'd0);
        wait_idle(0, cyc);
        expect_seq("skew_enc1", 2, 16'h0000, 0);
        chk("skew_enc1_latency", 32'(cyc), 32'd21);
        send(2'b10, 4'd0, 8'd0);
        wait_idle(0, cyc);
        expect_seq("skew_flush", 4, 16'h10F1, 1);

        // Reset in the middle of a division
        do_reset();
        send(2'b01, 4'd0, 8'd0);
        @(negedge clk);
        load_uniform();
        chk("middiv_pre_err", 32'(err), 1);
        send(2'b01, 4'd0, 8'd0);
        repeat (6) @(negedge clk);
        chk("middiv_busy", 32'(in_rdy), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("middiv_out_vld", 32'(out_vld), 0);
        chk("middiv_err", 32'(err), 0);
        chk("middiv_table_ok", 32'(table_ok), 0);
        chk("middiv_in_rdy", 32'(in_rdy), 0);
        rst = 1'b0;
        send(2'b10, 4'd0, 8'd0);
        wait_idle(0, cyc);
        expect_seq("middiv_flush", 4, 16'h1000, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
